// File: rtl/simon_host_if.sv
`default_nettype none
// ============================================================================
// Module   : simon_host_if
// Purpose  : Parallel valid/ready host wrapper around a bit-serial SIMON core:
//            serialises key and plaintext, waits out the core, collects the ct.
// Revision : 1.0
// ============================================================================
module simon_host_if #(
    parameter int KEY_W      = 128,
    parameter int BLOCK_W    = 64,
    parameter int RUN_CYCLES = 1408
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   key_in,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [BLOCK_W-1:0] pt_in,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic [BLOCK_W-1:0] ct_out,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic               busy,
    output logic               data_in,
    output logic [1:0]         data_rdy,
    input  logic               cipher_out
);

    localparam int MAX_KB = (KEY_W > BLOCK_W) ? KEY_W : BLOCK_W;
    localparam int MAX_N  = (MAX_KB > RUN_CYCLES) ? MAX_KB : RUN_CYCLES;
    localparam int CNT_W  = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_KEY = 3'd1,
        S_LOAD_PT  = 3'd2,
        S_RUN      = 3'd3,
        S_CAPTURE  = 3'd4,
        S_HOLD     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_loaded_q, key_loaded_d;
    logic [KEY_W-1:0]   key_sr_q, key_sr_d;
    logic [BLOCK_W-1:0] pt_sr_q, pt_sr_d;
    logic [BLOCK_W-1:0] ct_sr_q, ct_sr_d;
    logic [BLOCK_W-1:0] ct_out_q, ct_out_d;
    logic               data_in_q, data_in_d;
    logic [1:0]         data_rdy_q, data_rdy_d;
    logic               ct_valid_q, ct_valid_d;
    logic               busy_q, busy_d;
    logic               key_ready_q, key_ready_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        key_loaded_d = key_loaded_q;
        key_sr_d     = key_sr_q;
        pt_sr_d      = pt_sr_q;
        ct_sr_d      = ct_sr_q;
        ct_out_d     = ct_out_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (key_valid && key_ready_q) begin
                    key_sr_d = key_in;
                    state_d  = S_LOAD_KEY;
                end else if (pt_valid && pt_ready) begin
                    pt_sr_d = pt_in;
                    state_d = S_LOAD_PT;
                end
            end
            S_LOAD_KEY: begin
                // Rotate rather than shift so the key is intact after the load.
                key_sr_d = {key_sr_q[0], key_sr_q[KEY_W-1:1]};
                if (cnt_q == KEY_LAST) begin
                    key_loaded_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end
            end
            S_LOAD_PT: begin
                pt_sr_d = {1'b0, pt_sr_q[BLOCK_W-1:1]};
                if (cnt_q == BLK_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // First serial bit lands in ct bit 0 after BLOCK_W shifts.
                ct_sr_d = {cipher_out, ct_sr_q[BLOCK_W-1:1]};
                if (cnt_q == BLK_LAST) begin
                    cnt_d    = '0;
                    ct_out_d = ct_sr_d;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_d = '0;
                if (ct_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        data_rdy_d = 2'b00;
        data_in_d  = 1'b0;
        case (state_d)
            S_LOAD_KEY: begin
                data_rdy_d = 2'b01;
                data_in_d  = key_sr_d[0];
            end
            S_LOAD_PT: begin
                data_rdy_d = 2'b10;
                data_in_d  = pt_sr_d[0];
            end
            S_RUN, S_CAPTURE: data_rdy_d = 2'b11;
            default: ;
        endcase
        busy_d      = (state_d != S_IDLE);
        key_ready_d = (state_d == S_IDLE);
        ct_valid_d  = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            key_sr_q     <= '0;
            pt_sr_q      <= '0;
            ct_sr_q      <= '0;
            ct_out_q     <= '0;
            data_in_q    <= 1'b0;
            data_rdy_q   <= 2'b00;
            ct_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            key_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            key_sr_q     <= key_sr_d;
            pt_sr_q      <= pt_sr_d;
            ct_sr_q      <= ct_sr_d;
            ct_out_q     <= ct_out_d;
            data_in_q    <= data_in_d;
            data_rdy_q   <= data_rdy_d;
            ct_valid_q   <= ct_valid_d;
            busy_q       <= busy_d;
            key_ready_q  <= key_ready_d;
        end
    end

    // pt_ready must drop in the same cycle key_valid rises, so it stays combinational.
    assign pt_ready  = key_ready_q & key_loaded_q & ~key_valid;
    assign key_ready = key_ready_q;
    assign ct_out    = ct_out_q;
    assign ct_valid  = ct_valid_q;
    assign busy      = busy_q;
    assign data_in   = data_in_q;
    assign data_rdy  = data_rdy_q;

endmodule
`default_nettype wire

// File: doc/simon_host_if.md
SIMON_HOST_IF -- requirements
Module: simon_host_if

Interface
REQ-001 SHALL have parameter KEY_W, default 128, key width in bits.
REQ-002 SHALL have parameter BLOCK_W, default 64, plaintext/ciphertext width in bits.
REQ-003 SHALL have parameter RUN_CYCLES, default 1408, number of cycles the core computes before its ciphertext appears.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_in  in  KEY_W  parallel key.
REQ-007 SHALL have ports key_valid in 1 and key_ready out 1, forming the key handshake.
REQ-008 SHALL have port pt_in  in  BLOCK_W  parallel plaintext.
REQ-009 SHALL have ports pt_valid in 1 and pt_ready out 1, forming the plaintext handshake.
REQ-010 SHALL have port ct_out  out  BLOCK_W  parallel ciphertext.
REQ-011 SHALL have ports ct_valid out 1 and ct_ready in 1, forming the ciphertext handshake.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have ports data_in out 1 and data_rdy out 2, serial data and mode lines to simon_core.
REQ-014 SHALL have port cipher_out  in  1  serial ciphertext from simon_core.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_KEY, LOAD_PT, RUN, CAPTURE, HOLD.
REQ-016 data_rdy SHALL be: IDLE/HOLD 2'b00, LOAD_KEY 2'b01, LOAD_PT 2'b10, RUN/CAPTURE 2'b11.
REQ-017 A transfer SHALL occur on a cycle where valid and ready are both high.
REQ-018 key_ready SHALL be high only in IDLE.
REQ-019 pt_ready SHALL be high only in IDLE, with key_loaded=1, and with key_valid=0.
REQ-020 IDLE: on a key transfer, SHALL latch key_in into a shift register and go to LOAD_KEY; key has priority over pt when both are valid.
REQ-021 IDLE: on a pt transfer, SHALL latch pt_in and go to LOAD_PT.
REQ-022 LOAD_KEY SHALL drive data_in = key bit i on the i-th cycle, LSB first, for exactly KEY_W cycles, then set key_loaded=1 and return to IDLE.
REQ-023 LOAD_PT SHALL drive data_in LSB first for exactly BLOCK_W cycles, then go to RUN.
REQ-024 RUN SHALL last exactly RUN_CYCLES cycles with data_in=0, then go to CAPTURE.
REQ-025 CAPTURE SHALL sample cipher_out for BLOCK_W cycles; the first sample is ct bit 0; it then goes to HOLD.
REQ-026 HOLD SHALL hold ct_valid=1 with ct_out stable until ct_ready=1, then go to IDLE on the next cycle.
REQ-027 If ct_ready is already high on ct_valid's first cycle, ct_valid SHALL be a single-cycle pulse.
REQ-028 data_in SHALL be 0 outside LOAD_KEY and LOAD_PT.
REQ-029 The bit counter SHALL be clog2(max(KEY_W, BLOCK_W, RUN_CYCLES)+1) bits wide and cleared on every state entry.
REQ-030 The key SHALL be retained after loading; further plaintexts reuse it without reloading.
REQ-031 A new key transfer SHALL overwrite the retained key.
REQ-032 Input changes during LOAD_*, RUN or CAPTURE SHALL be ignored; only latched copies are used.

Reset
REQ-033 While rst_n=0, the block SHALL force: state IDLE, key_loaded=0, counter 0, data_in=0, data_rdy=2'b00, ct_out=0, ct_valid=0, key_ready=1, pt_ready=0, busy=0.
REQ-034 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL require a fresh key load.

Verification
REQ-035 pt_valid=1 after reset with no key loaded -> pt_ready stays 0 for 200 cycles; data_rdy stays 00.
REQ-036 key_in=128'h1b1a1918_13121110_0b0a0908_03020100 is transferred -> data_rdy=01 for 128 cycles; data_in follows 0,0,0,0,0,0,0,0,1,0,... (LSB first); then IDLE with pt_ready=1.
REQ-037 Against a simon_core instance, pt=64'h656b696c_20646e75 -> ct_out=64'h44c8fc20_b9dfa07a with ct_valid at cycle 64+RUN_CYCLES+64 after the pt handshake.
REQ-038 ct_ready held 0 for 50 cycles -> ct_valid and ct_out stay stable; pt_ready stays 0; IDLE is reached 1 cycle after ct_ready=1.
REQ-039 key_valid and pt_valid asserted together in IDLE -> key accepted, pt_ready=0 that cycle, pt accepted after the key load completes.
REQ-040 rst_n pulsed low at RUN cycle 500 -> all outputs match REQ-033 within the same cycle; pt_ready stays 0 until a new key is loaded.
